cdr_lock_controller: RTL and testbench
======================================

Name: cdr_lock_controller

Overview:
- Synthesizable digital acquisition/lock sequencer for the clock-recovery loop.
- Integrates phase-detector up/down activity over fixed windows.
- Steps a digital oscillator frequency code, coarse then fine, and declares or drops lock.
- Sits between the phase detector outputs (already synchronized to clk) and the DCO frequency input.

Parameters:
- CODE_W, 8: width of freq_code.
- CODE_INIT, 128: freq_code value loaded in IDLE.
- WIN_LEN, 16: window length in clk cycles; power of two, >= 4.
- COARSE_STEP, 8: code step in COARSE.
- FINE_STEP, 1: code step in FINE/LOCKED.
- LOCK_THR, 2: a window is "quiet" when |err| <= LOCK_THR.
- LOCK_CNT, 4: consecutive quiet windows needed to lock.
- UNLOCK_CNT, 2: consecutive noisy windows needed to drop lock.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  1 = run acquisition; 0 = return to IDLE.
- up  input  1  phase detector up (DCO early), sampled every clk.
- down  input  1  phase detector down (DCO late), sampled every clk.
- freq_code  output  CODE_W  DCO frequency code, registered.
- locked  output  1  registered; high only in LOCKED.
- lost_lock  output  1  one-cycle pulse on LOCKED->COARSE.
- state  output  2  current state encoding.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, freq_code=CODE_INIT, locked=0, lost_lock=0.
  - Window counter, err, quiet/bad counters and last_sign all cleared.
  - Reset asserted mid-window discards the partial window.
- Per-cycle error sample:
  - up&~down: +1. down&~up: -1. Both high or both low: 0.
  - err is signed, width $clog2(WIN_LEN)+2; it cannot overflow.
- Window:
  - win_cnt runs 0..WIN_LEN-1 in COARSE/FINE/LOCKED.
  - win_done is asserted when win_cnt==WIN_LEN-1. Evaluation uses err including that cycle's sample.
  - err and win_cnt clear for the next window.
  - All decisions and freq_code updates become visible the cycle after win_done.
- Direction: err>0 decrements freq_code; err<0 increments it; err==0 leaves it unchanged.
- Saturation: freq_code saturates at 0 and 2^CODE_W-1. No wrap-around.
- IDLE:
  - freq_code=CODE_INIT, counters clear.
  - en==1: go to COARSE next cycle; first window starts with win_cnt=0.
- COARSE, at win_done:
  - If |err|<=LOCK_THR: no step; go to FINE with quiet=1.
  - Else if sign(err) is opposite last_sign (nonzero last_sign): overshoot. Step FINE_STEP in the new direction; go to FINE with quiet=0.
  - Else: step COARSE_STEP and set last_sign=sign(err).
- FINE, at win_done:
  - Quiet window: quiet+1, no step. When quiet reaches LOCK_CNT, go to LOCKED and set locked=1.
  - Noisy window: quiet=0 and step FINE_STEP.
- LOCKED, at win_done:
  - Noisy window: step FINE_STEP, bad+1.
  - Quiet window: bad=0.
  - When bad reaches UNLOCK_CNT: go to COARSE, locked=0, lost_lock=1 for one cycle, last_sign=0, quiet=0, bad=0.
- en==0 in any state: IDLE on the next cycle.
  - freq_code reloads CODE_INIT, locked=0, partial window discarded.
  - No lost_lock pulse.
- Simultaneous en falling and win_done: en wins. That window is not evaluated.

Decomposition:
- Shared include cdr_ctrl_defs.vh holds:
  - state localparams: ST_IDLE=2'd0, ST_COARSE=2'd1, ST_FINE=2'd2, ST_LOCKED=2'd3;
  - sign encodings.
- One sub-module: cdr_err_window.
  - Inputs: clk, rst, clr, up, down.
  - Outputs: err (signed), win_done.
  - Contains the window counter and accumulator.
  - The top level keeps the FSM, code arithmetic and lock counters.

Test Plan (all parameters at default):
1. Reset: rst=0 for 2 cycles, en=1 → freq_code=128, state=0, locked=0, lost_lock=0. Reset asserted mid-window later returns the same values next cycle.
2. en=1, up=1/down=0 for 16 cycles → err=+16; freq_code=120 one cycle after win_done; state=COARSE.
3. Continue with one window of down=1 → overshoot detected; freq_code=121; state=FINE.
4. Four windows with up=down=0 (also repeat with up=down=1) → locked=1 and state=LOCKED one cycle after the 4th win_done; freq_code stays 121.
5. In LOCKED, two windows of up=1 → freq_code 120 then 119. After the second win_done: lost_lock high exactly one cycle, locked=0, state=COARSE.
6. CODE_INIT=4, up=1 continuously → freq_code 4→0, then stays 0 (no wrap). Drop en mid-window → next cycle state=IDLE, freq_code=4, no lost_lock.

Source files
------------

// File: rtl/cdr_lock_controller_pkg.sv
// Shared definitions for the CDR lock sequencer.
//   state_e : FSM state encoding, also driven out on the state port.
//   sign_e  : remembered direction of the last coarse step.
package cdr_lock_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SIGN_ZERO = 2'b00,
    SIGN_POS  = 2'b01,
    SIGN_NEG  = 2'b10
  } sign_e;

endpackage

// File: rtl/cdr_lock_controller_if.sv
// Signal bundle between the phase detector / DCO side and the lock sequencer.
//   en        : 1 = run acquisition, 0 = return to IDLE
//   up, down  : phase detector outputs, already synchronous to clk
//   freq_code : registered DCO frequency code
//   locked    : registered, high only in LOCKED
//   lost_lock : one-cycle pulse on LOCKED -> COARSE
//   state     : current FSM state (debug/observability)
// Handshake: there is no valid/ready pair; every input is a level sampled on
// each rising clk edge and every output is a registered level that is valid
// for the whole cycle after the edge that produced it.
interface cdr_lock_controller_if
  import cdr_lock_controller_pkg::*;
#(
  parameter int CODE_W = 8
);
  logic              en;
  logic              up;
  logic              down;
  logic [CODE_W-1:0] freq_code;
  logic              locked;
  logic              lost_lock;
  state_e            state;

  modport master (output en, up, down, input freq_code, locked, lost_lock, state);
  modport slave  (input en, up, down, output freq_code, locked, lost_lock, state);
endinterface

// File: rtl/cdr_err_window.sv
// Fixed-length window integrator for phase detector activity.
//   clk, rst : clock, synchronous active-low reset
//   clr      : hold the window counter and accumulator at zero
//   up, down : per-cycle samples (+1 / -1 / 0)
//   err      : signed running sum INCLUDING the current cycle's sample
//   win_done : high on the last cycle of a window (never while clr is high)
module cdr_err_window #(
  parameter int WIN_LEN = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 up,
  input  logic                                 down,
  output logic signed [$clog2(WIN_LEN)+1:0]    err,
  output logic                                 win_done
);
  localparam int CW = $clog2(WIN_LEN);
  localparam int EW = CW + 2;
  localparam logic signed [EW-1:0] ONE       = EW'(1);
  localparam logic signed [EW-1:0] MINUS_ONE = -EW'(1);

  logic [CW-1:0]          cnt_q;
  logic signed [EW-1:0]   acc_q;
  logic signed [EW-1:0]   smp;

  assign smp      = (up && !down) ? ONE : ((down && !up) ? MINUS_ONE : '0);
  // The decision at win_done must see the sample of that same cycle.
  assign err      = acc_q + smp;
  assign win_done = !clr && (cnt_q == CW'(WIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr || win_done) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      acc_q <= err;
    end
  end
endmodule

// File: rtl/cdr_lock_controller.sv
// CDR acquisition/lock sequencer: integrates phase detector error over fixed
// windows and walks the DCO frequency code coarse, then fine, declaring and
// dropping lock.
//   clk : system clock, all logic on posedge
//   rst : synchronous active-low reset
//   bus : slave side of cdr_lock_controller_if (en/up/down in,
//         freq_code/locked/lost_lock/state out)
module cdr_lock_controller
  import cdr_lock_controller_pkg::*;
#(
  parameter int CODE_W      = 8,
  parameter int CODE_INIT   = 128,
  parameter int WIN_LEN     = 16,
  parameter int COARSE_STEP = 8,
  parameter int FINE_STEP   = 1,
  parameter int LOCK_THR    = 2,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_CNT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cdr_lock_controller_if.slave bus
);
  localparam int EW = $clog2(WIN_LEN) + 2;
  localparam int QW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CODE_W-1:0]    CODE_INIT_V = CODE_W'(CODE_INIT);
  localparam logic signed [EW-1:0] THR         = EW'(LOCK_THR);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  sign_e               last_q, last_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic [BW-1:0]       bad_q, bad_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;

  logic signed [EW-1:0] err;
  logic                 win_done;
  logic                 win_clr;
  logic                 quiet_win;
  sign_e                err_sign;

  // The window only runs in the active states; leaving via en==0 discards it.
  assign win_clr = !bus.en || (state_q == ST_IDLE);

  cdr_err_window #(.WIN_LEN(WIN_LEN)) u_win (
    .clk      (clk),
    .rst      (rst),
    .clr      (win_clr),
    .up       (bus.up),
    .down     (bus.down),
    .err      (err),
    .win_done (win_done)
  );

  assign quiet_win = (err <= THR) && (err >= -THR);
  assign err_sign  = err[EW-1] ? SIGN_NEG : ((err != '0) ? SIGN_POS : SIGN_ZERO);

  // Positive error (DCO early) lowers the code; saturates at both ends.
  function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] code,
                                                  input int unsigned step,
                                                  input sign_e dir);
    int unsigned c;
    c = 32'(code);
    if (dir == SIGN_POS)
      return (c < step) ? '0 : CODE_W'(c - step);
    else if (dir == SIGN_NEG)
      return (c + step > ((32'd1 << CODE_W) - 32'd1)) ? '1 : CODE_W'(c + step);
    else
      return code;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      code_q   <= CODE_INIT_V;
      last_q   <= SIGN_ZERO;
      quiet_q  <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      last_q   <= last_d;
      quiet_q  <= quiet_d;
      bad_q    <= bad_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    last_d  = last_q;
    quiet_d = quiet_q;
    bad_d   = bad_q;
    lost_d  = 1'b0;
    if (!bus.en) begin
      // en has priority over a coincident win_done; no lost_lock pulse here.
      state_d = ST_IDLE;
      code_d  = CODE_INIT_V;
      last_d  = SIGN_ZERO;
      quiet_d = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COARSE;
          code_d  = CODE_INIT_V;
          last_d  = SIGN_ZERO;
          quiet_d = '0;
          bad_d   = '0;
        end
        ST_COARSE: begin
          if (win_done) begin
            if (quiet_win) begin
              state_d = ST_FINE;
              quiet_d = QW'(1);
            end else if (last_q != SIGN_ZERO && err_sign != last_q) begin
              // Overshoot: the error flipped, so back off by a fine step.
              code_d  = step_code(code_q, FINE_STEP, err_sign);
              state_d = ST_FINE;
              quiet_d = '0;
            end else begin
              code_d = step_code(code_q, COARSE_STEP, err_sign);
              last_d = err_sign;
            end
          end
        end
        ST_FINE: begin
          if (win_done) begin
            if (quiet_win) begin
              if (quiet_q + QW'(1) == QW'(LOCK_CNT)) begin
                state_d = ST_LOCKED;
                quiet_d = '0;
              end else begin
                quiet_d = quiet_q + QW'(1);
              end
            end else begin
              quiet_d = '0;
              code_d  = step_code(code_q, FINE_STEP, err_sign);
            end
          end
        end
        ST_LOCKED: begin
          if (win_done) begin
            if (quiet_win) begin
              bad_d = '0;
            end else begin
              code_d = step_code(code_q, FINE_STEP, err_sign);
              if (bad_q + BW'(1) == BW'(UNLOCK_CNT)) begin
                state_d = ST_COARSE;
                lost_d  = 1'b1;
                last_d  = SIGN_ZERO;
                quiet_d = '0;
                bad_d   = '0;
              end else begin
                bad_d = bad_q + BW'(1);
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  assign bus.freq_code = code_q;
  assign bus.locked    = locked_q;
  assign bus.lost_lock = lost_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_cdr_lock_controller.sv
module tb_cdr_lock_controller;
  localparam int WIN   = 16;
  localparam int THR   = 2;
  localparam int LCNT  = 4;
  localparam int UCNT  = 2;
  localparam int CSTEP = 8;
  localparam int FSTEP = 1;
  localparam int CMAX  = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdr_lock_controller_if #(.CODE_W(8)) bus_a ();
  cdr_lock_controller_if #(.CODE_W(8)) bus_b ();

  cdr_lock_controller #(.CODE_W(8), .CODE_INIT(128), .WIN_LEN(WIN), .COARSE_STEP(CSTEP),
                        .FINE_STEP(FSTEP), .LOCK_THR(THR), .LOCK_CNT(LCNT), .UNLOCK_CNT(UCNT))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  cdr_lock_controller #(.CODE_W(8), .CODE_INIT(4), .WIN_LEN(WIN), .COARSE_STEP(CSTEP),
                        .FINE_STEP(FSTEP), .LOCK_THR(THR), .LOCK_CNT(LCNT), .UNLOCK_CNT(UCNT))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- reference model (window level) ----------------
  // Modes use the published encoding: 0 idle, 1 coarse, 2 fine, 3 locked.
  int m_init[2] = '{128, 4};
  int m_mode[2], m_code[2], m_last[2], m_quiet[2], m_bad[2], m_lost[2], m_sum[2], m_n[2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];   // {mode[1:0], locked, lost, code[7:0]}

  function automatic int sat(input int x);
    return (x < 0) ? 0 : ((x > CMAX) ? CMAX : x);
  endfunction

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  task automatic model_idle(input int k);
    m_mode[k] = 0; m_code[k] = m_init[k]; m_last[k] = 0;
    m_quiet[k] = 0; m_bad[k] = 0; m_sum[k] = 0; m_n[k] = 0;
  endtask

  task automatic model_window(input int k, input int e);
    bit q;
    int dir;
    q   = (e <= THR) && (e >= -THR);
    dir = -sgn(e);   // positive error lowers the code
    case (m_mode[k])
      1: begin
        if (q) begin
          m_mode[k] = 2; m_quiet[k] = 1;
        end else if (m_last[k] != 0 && sgn(e) != m_last[k]) begin
          m_code[k] = sat(m_code[k] + dir * FSTEP); m_mode[k] = 2; m_quiet[k] = 0;
        end else begin
          m_code[k] = sat(m_code[k] + dir * CSTEP); m_last[k] = sgn(e);
        end
      end
      2: begin
        if (q) begin
          m_quiet[k]++;
          if (m_quiet[k] == LCNT) m_mode[k] = 3;
        end else begin
          m_quiet[k] = 0; m_code[k] = sat(m_code[k] + dir * FSTEP);
        end
      end
      3: begin
        if (q) m_bad[k] = 0;
        else begin
          m_code[k] = sat(m_code[k] + dir * FSTEP);
          m_bad[k]++;
        end
        if (m_bad[k] == UCNT) begin
          m_mode[k] = 1; m_lost[k] = 1; m_last[k] = 0; m_quiet[k] = 0; m_bad[k] = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_cycle(input int k, input bit r, input bit e, input bit u, input bit d);
    m_lost[k] = 0;
    if (!r || !e) begin
      model_idle(k);
    end else if (m_mode[k] == 0) begin
      model_idle(k);
      m_mode[k] = 1;
    end else begin
      m_sum[k] += (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      m_n[k]++;
      if (m_n[k] == WIN) begin
        model_window(k, m_sum[k]);
        m_sum[k] = 0;
        m_n[k] = 0;
      end
    end
    exp_q.push_back({2'(m_mode[k]), (m_mode[k] == 3), 1'(m_lost[k]), 8'(m_code[k])});
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic scoreboard_compare();
    logic [11:0] e;
    for (int k = 0; k < 2; k++) begin
      string nm;
      logic [7:0] code;
      logic [1:0] st;
      logic lk, ls;
      nm   = (k == 0) ? "A" : "B";
      code = (k == 0) ? bus_a.freq_code : bus_b.freq_code;
      st   = (k == 0) ? bus_a.state     : bus_b.state;
      lk   = (k == 0) ? bus_a.locked    : bus_b.locked;
      ls   = (k == 0) ? bus_a.lost_lock : bus_b.lost_lock;
      if (exp_q.size() == 0) begin
        check_val({nm, ".exp_q_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_val({nm, ".freq_code"}, 32'(code), 32'(e[7:0]));
        check_val({nm, ".state"},     32'(st),   32'(e[11:10]));
        check_val({nm, ".locked"},    32'(lk),   32'(e[9]));
        check_val({nm, ".lost_lock"}, 32'(ls),   32'(e[8]));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit e, input bit u, input bit d);
    @(negedge clk);
    rst = r;
    bus_a.en = e; bus_a.up = u; bus_a.down = d;
    bus_b.en = e; bus_b.up = u; bus_b.down = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_cycle(k, r, e, u, d);
    #1;
    scoreboard_compare();
  endtask

  task automatic run_n(input int n, input bit u, input bit d);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, u, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bias;
    bit r, e, u, d;
    rst = 1'b0;
    bus_a.en = 1'b0; bus_a.up = 1'b0; bus_a.down = 1'b0;
    bus_b.en = 1'b0; bus_b.up = 1'b0; bus_b.down = 1'b0;
    for (int k = 0; k < 2; k++) begin model_idle(k); m_lost[k] = 0; end

    // Reset for two cycles with en high.
    step(1'b0, 1'b1, 1'b0, 0); step(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("reset.A.code", 32'(bus_a.freq_code), 32'd128);
    check_val("reset.A.state", 32'(bus_a.state), 32'd0);
    check_val("reset.A.locked", 32'(bus_a.locked), 32'd0);

    step(1'b1, 1'b1, 1'b0, 1'b0);            // IDLE -> COARSE
    run_n(WIN, 1'b1, 1'b0);                  // err = +16
    check_val("coarse.A.code", 32'(bus_a.freq_code), 32'd120);
    check_val("coarse.A.state", 32'(bus_a.state), 32'd1);
    check_val("coarse.B.code_sat0", 32'(bus_b.freq_code), 32'd0);

    run_n(WIN, 1'b0, 1'b1);                  // overshoot
    check_val("overshoot.A.code", 32'(bus_a.freq_code), 32'd121);
    check_val("overshoot.A.state", 32'(bus_a.state), 32'd2);

    run_n(4 * WIN, 1'b0, 1'b0);              // four quiet windows
    check_val("lock.A.locked", 32'(bus_a.locked), 32'd1);
    check_val("lock.A.state", 32'(bus_a.state), 32'd3);
    check_val("lock.A.code", 32'(bus_a.freq_code), 32'd121);

    run_n(2 * WIN, 1'b1, 1'b1);              // quiet with both high: stays locked
    check_val("lock_both.A.locked", 32'(bus_a.locked), 32'd1);

    run_n(WIN, 1'b1, 1'b0);
    check_val("unlock1.A.code", 32'(bus_a.freq_code), 32'd120);
    run_n(WIN, 1'b1, 1'b0);
    check_val("unlock2.A.code", 32'(bus_a.freq_code), 32'd119);
    check_val("unlock2.A.lost_lock", 32'(bus_a.lost_lock), 32'd1);
    check_val("unlock2.A.state", 32'(bus_a.state), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("unlock3.A.lost_lock", 32'(bus_a.lost_lock), 32'd0);

    run_n(5, 1'b1, 1'b0);                    // reset mid-window
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("midreset.A.code", 32'(bus_a.freq_code), 32'd128);
    check_val("midreset.A.state", 32'(bus_a.state), 32'd0);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_n(5 * WIN, 1'b1, 1'b0);              // B pinned at 0
    check_val("sat0.B.code", 32'(bus_b.freq_code), 32'd0);
    run_n(7, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);            // en dropped mid-window
    check_val("endrop.B.state", 32'(bus_b.state), 32'd0);
    check_val("endrop.B.code", 32'(bus_b.freq_code), 32'd4);
    check_val("endrop.B.lost_lock", 32'(bus_b.lost_lock), 32'd0);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_n(17 * WIN, 1'b0, 1'b1);             // A walks up and pins at 255
    check_val("satmax.A.code", 32'(bus_a.freq_code), 32'd255);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run_n(WIN - 1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);            // en falls on the win_done cycle
    check_val("en_vs_windone.A.code", 32'(bus_a.freq_code), 32'd128);
    check_val("en_vs_windone.A.state", 32'(bus_a.state), 32'd0);

    bias = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % WIN == 0) bias = $urandom_range(0, 3);
      r = ($urandom_range(0, 399) != 0);
      e = ($urandom_range(0, 249) != 0);
      case (bias)
        0: begin u = 1'($urandom_range(0, 1)); d = ($urandom_range(0, 24) == 0) ? ~u : u; end
        1: begin u = ($urandom_range(0, 9) != 0); d = ($urandom_range(0, 9) == 0); end
        2: begin d = ($urandom_range(0, 9) != 0); u = ($urandom_range(0, 9) == 0); end
        default: begin u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); end
      endcase
      step(r, e, u, d);
    end

    check_val("final.exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
